// File: rtl/safe_pkg.sv
// Shared types and timing constants for the safe controller front end.
// Consumers: key_debounce_pulse (optional feature macro KEY_LONG_PRESS_EN).
package safe_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } key_state_t;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned DEBOUNCE_20MS = 1_000_000;
  localparam int unsigned LONG_1S       = 50_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs with a configurable reset value.
// Shared by push-button and slide-switch inputs.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_ff1;
  logic [WIDTH-1:0] r_ff2;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_ff1 <= RESET_VAL;
      r_ff2 <= RESET_VAL;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounces an active-low push-button into a level plus press/release strobes.
// Define KEY_LONG_PRESS_EN to enable the one-shot long_press strobe.
module key_debounce_pulse
  import safe_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int unsigned LONG_CYCLES     = LONG_1S
) (
  input  logic clk,
  input  logic RESET,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic release_p,
  output logic long_press
);

  localparam int unsigned CNT_W = $clog2(max_u(DEBOUNCE_CYCLES, LONG_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
`ifdef KEY_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_C    = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_M1_C = CNT_W'(LONG_CYCLES - 1);
`endif

  logic       w_key_sync;
  logic       w_pressed_s;
  key_state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic       r_level;
  logic       r_press;
  logic       r_release_p;
  logic       r_long_press;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .RESET(RESET),
    .i_d  (key_n),
    .o_q  (w_key_sync)
  );

  assign w_pressed_s = ~w_key_sync;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_level      <= 1'b0;
      r_press      <= 1'b0;
      r_release_p  <= 1'b0;
      r_long_press <= 1'b0;
    end else begin
      r_press      <= 1'b0;
      r_release_p  <= 1'b0;
      r_long_press <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pressed_s) begin
            r_state <= PRESS_CHK;
            r_cnt   <= ONE_C;
          end else begin
            r_cnt <= '0;
          end
        end
        PRESS_CHK: begin
          if (!w_pressed_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_C) begin
            r_state <= HELD;
            r_press <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ONE_C;
          end
        end
        HELD: begin
          if (!w_pressed_s) begin
            r_state <= REL_CHK;
            r_cnt   <= ONE_C;
          end
`ifdef KEY_LONG_PRESS_EN
          // Timer saturates at LONG_CYCLES so the strobe fires once per hold.
          else if (r_cnt != LONG_C) begin
            r_cnt <= r_cnt + ONE_C;
            if (r_cnt == LONG_M1_C) r_long_press <= 1'b1;
          end
`endif
        end
        REL_CHK: begin
          if (w_pressed_s) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_C) begin
            r_state     <= IDLE;
            r_release_p <= 1'b1;
            r_level     <= 1'b0;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + ONE_C;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign level      = r_level;
  assign press      = r_press;
  assign release_p  = r_release_p;
  assign long_press = r_long_press;

  a_no_press_and_release: assert property (@(posedge clk) disable iff (RESET)
    !(r_press && r_release_p));

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: directed scenarios plus random bouncing, all checked
// against a run-length reference model. Works with or without KEY_LONG_PRESS_EN.
module tb_key_debounce_pulse;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 10;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  logic clk;
  logic RESET;
  logic key_n;
  logic level;
  logic press;
  logic release_p;
  logic long_press;

  int vecs;
  int miscompares;

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .key_n     (key_n),
    .level     (level),
    .press     (press),
    .release_p (release_p),
    .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the button is seen two samples late; a change of the accepted level
  // needs DEB+1 consecutive disagreeing samples. The long timer counts undisturbed held
  // samples since acceptance or since the last release bounce.
  logic     m_h1, m_h2, m_level;
  int       m_run, m_hold;
  logic [3:0] m_exp;

  task automatic model_edge(input logic k, input logic rst);
    logic s, p, r, lp;
    p = 1'b0; r = 1'b0; lp = 1'b0;
    if (rst) begin
      m_h1 = 1'b1; m_h2 = 1'b1; m_level = 1'b0; m_run = 0; m_hold = 0;
      m_exp = 4'b0000;
      return;
    end
    s    = ~m_h2;
    m_h2 = m_h1;
    m_h1 = k;
    if (s != m_level) begin
      m_run++;
      if (m_run == int'(DEB) + 1) begin
        m_level = s;
        p = s;
        r = ~s;
        m_run = 0;
        m_hold = 0;
      end
    end else begin
      if (m_level) begin
        if (m_run != 0) m_hold = 0;
        else if (m_hold < int'(LONG)) begin
          m_hold++;
          if (m_hold == int'(LONG)) lp = LongEn;
        end
      end
      m_run = 0;
    end
    m_exp = {m_level, p, r, lp};
  endtask

  task automatic tick(input logic k, input logic rst);
    key_n = k;
    RESET = rst;
    @(posedge clk);
    model_edge(k, rst);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, (i < 2));
      vecs++;
      if ({level, press, release_p, long_press} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset cycle %0d: got %b expected 0000", i,
                 {level, press, release_p, long_press});
      end
    end
  endtask

  task automatic test_clean_press();
    int press_at, n_press;
    press_at = -1; n_press = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b0);
      if (press) begin n_press++; if (press_at < 0) press_at = k; end
      vecs++;
      if ({level, press, release_p, long_press} !== m_exp) begin
        miscompares++;
        $display("FAIL clean_press cycle %0d: got %b expected %b", k,
                 {level, press, release_p, long_press}, m_exp);
      end
    end
    vecs++;
    if (press_at != 6 || n_press != 1) begin
      miscompares++;
      $display("FAIL clean_press_latency: got edge %0d count %0d expected edge 6 count 1",
               press_at, n_press);
    end
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, 1'b0);
      vecs++;
      if ({level, press, release_p, long_press} !== m_exp) begin
        miscompares++;
        $display("FAIL clean_release cycle %0d: got %b expected %b", k,
                 {level, press, release_p, long_press}, m_exp);
      end
    end
  endtask

  task automatic test_bounce_reject();
    logic [15:0] pat;
    int seen;
    pat = 16'b1111111111_00_1_000; // bit k is key_n at cycle k
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      tick(pat[k], 1'b0);
      if (press || release_p || level) seen++;
      vecs++;
      if ({level, press, release_p, long_press} !== m_exp) begin
        miscompares++;
        $display("FAIL bounce cycle %0d: got %b expected %b", k,
                 {level, press, release_p, long_press}, m_exp);
      end
    end
    vecs++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL bounce_quiet: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_release_glitch();
    logic [12:0] pat;
    int rel_at, n_rel;
    pat = 13'b1111111111_0_11;
    rel_at = -1; n_rel = 0;
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b0);
    vecs++;
    if (level !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_setup_level: got %b expected 1", level);
    end
    for (int k = 0; k < 13; k++) begin
      tick(pat[k], 1'b0);
      if (release_p) begin n_rel++; if (rel_at < 0) rel_at = k; end
      vecs++;
      if ({level, press, release_p, long_press} !== m_exp) begin
        miscompares++;
        $display("FAIL glitch cycle %0d: got %b expected %b", k,
                 {level, press, release_p, long_press}, m_exp);
      end
    end
    vecs++;
    if (rel_at != 9 || n_rel != 1 || level !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_release: got edge %0d count %0d level %b expected 9 1 0",
               rel_at, n_rel, level);
    end
  endtask

  task automatic test_reset_mid();
    int early, press_at, n_press;
    early = 0; press_at = -1; n_press = 0;
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b0);
      if (press) early++;
    end
    tick(1'b0, 1'b1);
    if (press) early++;
    for (int j = 0; j < 15; j++) begin
      tick(1'b0, 1'b0);
      if (press) begin n_press++; if (press_at < 0) press_at = j; end
      vecs++;
      if ({level, press, release_p, long_press} !== m_exp) begin
        miscompares++;
        $display("FAIL reset_mid cycle %0d: got %b expected %b", j,
                 {level, press, release_p, long_press}, m_exp);
      end
    end
    vecs++;
    if (early != 0 || press_at != 6 || n_press != 1) begin
      miscompares++;
      $display("FAIL reset_mid_press: got early %0d edge %0d count %0d expected 0 6 1",
               early, press_at, n_press);
    end
    for (int k = 0; k < 20; k++) tick(1'b1, 1'b0);
  endtask

  task automatic test_long_press();
    int long_at, n_long, exp_at, exp_n;
    long_at = -1; n_long = 0;
    exp_at = LongEn ? 16 : -1;
    exp_n  = LongEn ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, 1'b0);
      if (long_press) begin n_long++; if (long_at < 0) long_at = k; end
      vecs++;
      if ({level, press, release_p, long_press} !== m_exp) begin
        miscompares++;
        $display("FAIL long cycle %0d: got %b expected %b", k,
                 {level, press, release_p, long_press}, m_exp);
      end
    end
    vecs++;
    if (long_at != exp_at || n_long != exp_n) begin
      miscompares++;
      $display("FAIL long_press_once: got edge %0d count %0d expected %0d %0d",
               long_at, n_long, exp_at, exp_n);
    end
    for (int k = 0; k < 20; k++) tick(1'b1, 1'b0);
  endtask

  task automatic test_two_presses();
    logic [19:0] pat;
    int n_press, n_rel;
    pat = 20'b1111111111_0000000_010; // 2-cycle bounce, then a solid hold
    n_press = 0; n_rel = 0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 20; k++) begin
        tick(pat[k], 1'b0);
        if (press) n_press++;
        if (release_p) n_rel++;
        vecs++;
        if ({level, press, release_p, long_press} !== m_exp) begin
          miscompares++;
          $display("FAIL two_presses rep %0d cycle %0d: got %b expected %b", rep, k,
                   {level, press, release_p, long_press}, m_exp);
        end
      end
    end
    vecs++;
    if (n_press != 2 || n_rel != 2) begin
      miscompares++;
      $display("FAIL two_presses_count: got %0d presses %0d releases expected 2 2",
               n_press, n_rel);
    end
  endtask

  task automatic test_random();
    logic k;
    int run;
    k = 1'b1; run = 0;
    for (int c = 0; c < 1500; c++) begin
      if (run == 0) begin
        k = ~k;
        run = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 25) : $urandom_range(1, 6);
      end
      run--;
      tick(k, ($urandom_range(0, 199) == 0));
      vecs++;
      if ({level, press, release_p, long_press} !== m_exp || (press && release_p)) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %b expected %b", c,
                 {level, press, release_p, long_press}, m_exp);
      end
    end
  endtask

  initial begin
    vecs = 0;
    miscompares = 0;
    key_n = 1'b1;
    RESET = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_release_glitch();
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    test_reset_mid();
    test_long_press();
    test_two_presses();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
